// File: rtl/rom_reader_pkg.sv
// Shared defaults and state encoding for the ROM sequencing reader.
package rom_reader_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned SUM_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DONE
  } state_t;

endpackage

// File: rtl/rom_reader.sv
// Walks a (possibly wrapping) ROM address range, streams each word out on a
// valid/ready port with a last flag, and keeps a running sum of accepted words.
module rom_reader #(
  parameter int unsigned ADDR_W = rom_reader_pkg::ADDR_W,
  parameter int unsigned DATA_W = rom_reader_pkg::DATA_W,
  parameter int unsigned SUM_W  = rom_reader_pkg::SUM_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_first_addr,
  input  logic [ADDR_W-1:0] i_last_addr,
  output logic [ADDR_W-1:0] o_rom_addr_out,
  input  logic [DATA_W-1:0] i_rom_data_in,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_out_last,
  output logic              o_busy,
  output logic              o_done,
  output logic [SUM_W-1:0]  o_sum
);
  import rom_reader_pkg::*;

  state_t            r_state;
  state_t            w_state_d;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_end;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic [SUM_W-1:0]  r_sum;
  logic              w_accept;

  assign w_accept = (r_state == HOLD) && i_out_ready;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (i_start) w_state_d = FETCH;
      FETCH:   w_state_d = HOLD;
      HOLD:    if (i_out_ready) w_state_d = r_last ? DONE : FETCH;
      DONE:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_end   <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_sum   <= '0;
    end else begin
      r_state <= w_state_d;
      if ((r_state == IDLE) && i_start) begin
        r_addr <= i_first_addr;
        r_end  <= i_last_addr;
        r_sum  <= '0;
      end
      if (r_state == FETCH) begin
        r_data <= i_rom_data_in;
        r_last <= (r_addr == r_end);
      end
      if (w_accept) begin
        r_sum <= r_sum + SUM_W'(r_data);
        // Natural overflow of the add gives the 7 -> 0 wrap.
        if (!r_last) r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

  assign o_rom_addr_out = r_addr;
  assign o_out_data     = r_data;
  assign o_out_last     = r_last;
  assign o_out_valid    = (r_state == HOLD);
  assign o_busy         = (r_state != IDLE);
  assign o_done         = (r_state == DONE);
  assign o_sum          = r_sum;

endmodule
